// File: rtl/serial_sub.sv
// serial_sub: bit-serial WIDTH-bit subtractor, LSB first; SERIAL_SUB_OVF_EN adds the ovf port
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_OVF_EN
  , output logic           ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic [CW-1:0] cnt;
  logic br, d, bo, last;
  assign d = a_sh[0] ^ b_sh[0] ^ br;
  assign bo = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
  assign last = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state == IDLE ? (start ? SHIFT : IDLE) : state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
    busy = state == SHIFT;
    done = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      res <= '0;
      br <= 1'b0;
      cnt <= '0;
      diff <= '0;
      borrow_out <= 1'b0;
    end else if (state == IDLE && start) begin
      a_sh <= a;
      b_sh <= b;
      br <= bin;
      cnt <= '0;
      res <= '0;
    end else if (state == SHIFT) begin
      res <= {d, res[WIDTH-1:1]};
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      br <= bo;
      cnt <= cnt + 1'b1;
      if (last) begin
        diff <= {d, res[WIDTH-1:1]};
        borrow_out <= bo;
      end
    end
`ifdef SERIAL_SUB_OVF_EN
  logic [1:0] msb;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      msb <= 2'b00;
      ovf <= 1'b0;
    end else if (state == IDLE && start) msb <= {a[WIDTH-1], b[WIDTH-1]};
    else if (state == SHIFT && last) ovf <= (msb[1] != msb[0]) && (d != msb[1]);
`endif
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: randomized self-checking bench for serial_sub against an arithmetic model
module tb_serial_sub;
  localparam int W = 8;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, bin = 1'b0;
  logic [W-1:0] a = '0, b = '0, diff;
  logic borrow_out, busy, done;
  int checks = 0, errors = 0;
  logic [W-1:0] prev_d = '0;
  logic prev_b = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
  logic ovf;
  logic prev_o = 1'b0;
`endif
  serial_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .diff(diff), .borrow_out(borrow_out), .busy(busy), .done(done)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin, input bit noise);
    int t;
    logic [W-1:0] ed;
    logic eb;
    t = int'(ta) - int'(tb) - int'(tbin);
    ed = t[W-1:0];
    eb = t < 0;
    @(negedge clk);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("busy", {busy, done}, 2'b10);
      check("hold", {borrow_out, diff}, {prev_b, prev_d});
      start = noise && (i == 1 || i == 4);
      a = W'($urandom); b = W'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    check("done", {busy, done}, 2'b01);
    check("diff", diff, ed);
    check("borrow", borrow_out, eb);
`ifdef SERIAL_SUB_OVF_EN
    prev_o = (ta[W-1] != tb[W-1]) && (ed[W-1] != ta[W-1]);
    check("ovf", ovf, prev_o);
`endif
    prev_d = ed;
    prev_b = eb;
    @(negedge clk);
    check("idle", {busy, done}, 2'b00);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst", {busy, done, borrow_out, diff}, 11'h0);
    run_op(8'h5A, 8'h23, 1'b0, 1'b0);
    run_op(8'h00, 8'h01, 1'b0, 1'b0);
    run_op(8'h10, 8'h10, 1'b1, 1'b0);
    run_op(8'hC3, 8'h3C, 1'b0, 1'b1);
    #3 rst_n = 1'b0;
    #1 check("rst_idle", {busy, done, borrow_out, diff}, 11'h0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", ovf, 1'b0);
`endif
    prev_d = '0; prev_b = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a = 8'hF0; b = 8'h0F; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1 check("rst_shift", {busy, done, borrow_out, diff}, 11'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hold", {busy, done}, 2'b00);
    end
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      check("no_done", {busy, done}, 2'b00);
    end
    run_op(8'h09, 8'h04, 1'b0, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    run_op(8'h80, 8'h01, 1'b0, 1'b0);
    run_op(8'h05, 8'h03, 1'b0, 1'b0);
`endif
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    run_op(8'h00, 8'hFF, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
